// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings and the minimum baud divisor.
// Used by uart_rx_core and uart_tx_core.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } uart_state_e;

   localparam int unsigned MIN_DIV = 4;

endpackage

// File: rtl/uart_rx_sync.sv
// RX pin synchronizer: SYNC_STAGES flop chain (idle high) plus a falling-edge strobe
// on the synchronized line.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rxs,
   output logic rx_fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   rxs_d;

   // NOTE: reset to the idle level (1), not 0, so leaving reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '1;
         rxs_d <= 1'b1;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], rx};
         rxs_d <= chain[SYNC_STAGES-1];
      end
   end

   assign rxs     = chain[SYNC_STAGES-1];
   assign rx_fall = rxs_d & ~rxs;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start validation, LSB-first shifting, stop/parity checks and a one-entry
// valid/ready holding buffer. Optional parity is enabled with `define UART_RX_PARITY_EN.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
`ifdef UART_RX_PARITY_EN
   input  logic                 parity_odd,
`endif
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   logic rxs;
   logic rx_fall;

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rxs     (rxs),
      .rx_fall (rx_fall)
   );

   uart_state_e          state, state_n;
   logic [DIV_W-1:0]     div, div_eff, cnt, cnt_n, half_m1, full_m1;
   logic [3:0]           bit_idx, bit_n;
   logic [DATA_BITS-1:0] shreg;
   logic                 load_div, shift_en, frame_good, frame_bad;
`ifdef UART_RX_PARITY_EN
   logic                 par_sample, par_err_q;
`endif

   assign div_eff = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
   assign half_m1 = (div >> 1) - DIV_W'(1);
   assign full_m1 = div - DIV_W'(1);
   assign busy    = (state != ST_IDLE);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt + DIV_W'(1);
      bit_n      = bit_idx;
      load_div   = 1'b0;
      shift_en   = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_sample = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (rx_fall) begin
               state_n  = ST_START;
               load_div = 1'b1;
            end
         end
         ST_START: begin
            if (cnt == half_m1) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt == full_m1) begin
               cnt_n    = '0;
               shift_en = 1'b1;
               bit_n    = bit_idx + 4'd1;
               if (bit_idx == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt == full_m1) begin
               cnt_n      = '0;
               par_sample = 1'b1;
               state_n    = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt == full_m1) begin
               cnt_n = '0;
               if (rxs) begin
                  frame_good = 1'b1;
                  state_n    = ST_IDLE;
               end else begin
                  frame_bad = 1'b1;
                  state_n   = ST_BRK;
               end
            end
         end
         ST_BRK: begin
            cnt_n = '0;
            if (rxs) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         div     <= DIV_W'(MIN_DIV);
         shreg   <= '0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         if (load_div) div <= div_eff;
         if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
         if (par_sample) par_err_q <= (^shreg) ^ rxs ^ parity_odd;
`endif
      end
   end

   // Holding buffer: a completed frame wins over a same-cycle drain, so valid stays up.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= frame_bad;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (frame_good) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
               parity_err <= par_err_q;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized back-to-back frames
// checked against a frame-level reference (sent bytes and expected flag pulse counts).
module tb_uart_rx_core;

   localparam int DATA_BITS = 8;
   localparam int DIV_W     = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [DIV_W-1:0]     baud_div;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;
   logic                 busy;
`ifdef UART_RX_PARITY_EN
   logic                 parity_odd;
`endif

   uart_rx_core #(.DATA_BITS(DATA_BITS), .DIV_W(DIV_W), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_div   (baud_div),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
`ifdef UART_RX_PARITY_EN
      .parity_odd (parity_odd),
`endif
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor: cycle counts of each output and a log of handshaken bytes.
   int         valid_cyc = 0, fe_cyc = 0, pe_cyc = 0, ov_cyc = 0, busy_cyc = 0, got_n = 0;
   logic [7:0] got_mem [0:255];

   always @(negedge clk) begin
      #1;
      if (rx_valid)   valid_cyc++;
      if (frame_err)  fe_cyc++;
      if (parity_err) pe_cyc++;
      if (overrun)    ov_cyc++;
      if (busy)       busy_cyc++;
      if (rx_valid && rx_ready) begin
         got_mem[got_n[7:0]] = rx_data;
         got_n++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got_n=%0d required run to finish", got_n);
      $fatal(1, "watchdog");
   end

   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive_bit(1'b1, n);
   endtask

   // One frame at bit_clks clocks per bit; optionally reprograms baud_div during data bit 2.
   task automatic send_frame(input logic [7:0] data, input int bit_clks, input logic stop_val,
                             input logic par_flip, input bit set_div, input logic [DIV_W-1:0] nd);
      drive_bit(1'b0, bit_clks);
      for (int i = 0; i < DATA_BITS; i++) begin
         if (set_div && i == 2) baud_div = nd;
         drive_bit(data[i], bit_clks);
      end
`ifdef UART_RX_PARITY_EN
      drive_bit((^data) ^ parity_odd ^ par_flip, bit_clks);
`endif
      drive_bit(stop_val, bit_clks);
   endtask

   function automatic logic [23:0] flag_deltas(input int fe0, input int pe0, input int ov0);
      return {8'(fe_cyc - fe0), 8'(pe_cyc - pe0), 8'(ov_cyc - ov0)};
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rx_valid, busy, frame_err, parity_err, overrun} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: valid,busy,fe,pe,ov=%b required 00000",
                  {rx_valid, busy, frame_err, parity_err, overrun});
      end
      n_checks++;
      if (rx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: rx_data=%h required 00", rx_data);
      end
      rst = 1'b0;
      idle(4);
   endtask

   task automatic test_basic;
      int g0 = got_n, v0 = valid_cyc, fe0 = fe_cyc, pe0 = pe_cyc, ov0 = ov_cyc;
      baud_div = 16'd8;
      rx_ready = 1'b1;
      send_frame(8'hAA, 8, 1'b1, 1'b0, 1'b0, '0);
      idle(16);
      n_checks++;
      if (got_n - g0 !== 1) begin
         n_fail++;
         $display("FAIL basic_count: bytes=%0d required 1", got_n - g0);
      end else begin
         n_checks++;
         if (got_mem[g0[7:0]] !== 8'hAA) begin
            n_fail++;
            $display("FAIL basic_data: rx_data=%h required aa", got_mem[g0[7:0]]);
         end
      end
      n_checks++;
      if (valid_cyc - v0 !== 1) begin
         n_fail++;
         $display("FAIL basic_valid_width: cycles=%0d required 1", valid_cyc - v0);
      end
      n_checks++;
      if (flag_deltas(fe0, pe0, ov0) !== 24'h000000) begin
         n_fail++;
         $display("FAIL basic_flags: fe/pe/ov=%h required 000000", flag_deltas(fe0, pe0, ov0));
      end
   endtask

   task automatic test_glitch;
      int b0 = busy_cyc, v0 = valid_cyc, fe0 = fe_cyc;
      baud_div = 16'd8;
      drive_bit(1'b0, 2);
      idle(20);
      n_checks++;
      if (busy_cyc - b0 > 4) begin
         n_fail++;
         $display("FAIL glitch_busy: busy cycles=%0d required <=4", busy_cyc - b0);
      end
      n_checks++;
      if ({busy, 8'(valid_cyc - v0), 8'(fe_cyc - fe0)} !== 17'h0) begin
         n_fail++;
         $display("FAIL glitch_quiet: busy=%b valid=%0d fe=%0d required 0 0 0",
                  busy, valid_cyc - v0, fe_cyc - fe0);
      end
   endtask

   task automatic test_break;
      int g0 = got_n, fe0 = fe_cyc, pe0 = pe_cyc, ov0 = ov_cyc;
      baud_div = 16'd8;
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, '0);
      drive_bit(1'b0, 40);
      idle(16);
      n_checks++;
      if (flag_deltas(fe0, pe0, ov0) !== 24'h010000) begin
         n_fail++;
         $display("FAIL break_flags: fe/pe/ov=%h required 010000", flag_deltas(fe0, pe0, ov0));
      end
      n_checks++;
      if (got_n !== g0) begin
         n_fail++;
         $display("FAIL break_dropped: bytes=%0d required 0", got_n - g0);
      end
      send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, '0);
      idle(16);
      n_checks++;
      if (got_n - g0 !== 1 || got_mem[g0[7:0]] !== 8'h3C) begin
         n_fail++;
         $display("FAIL break_next: bytes=%0d first=%h required 1 3c", got_n - g0, got_mem[g0[7:0]]);
      end
   endtask

   task automatic test_overrun;
      int g0 = got_n, ov0 = ov_cyc;
      baud_div = 16'd8;
      rx_ready = 1'b0;
      send_frame(8'h11, 8, 1'b1, 1'b0, 1'b0, '0);
      idle(16);
      n_checks++;
      if ({rx_valid, rx_data, 8'(ov_cyc - ov0)} !== {1'b1, 8'h11, 8'd0}) begin
         n_fail++;
         $display("FAIL overrun_first: valid=%b data=%h ov=%0d required 1 11 0",
                  rx_valid, rx_data, ov_cyc - ov0);
      end
      send_frame(8'h22, 8, 1'b1, 1'b0, 1'b0, '0);
      idle(16);
      n_checks++;
      if ({rx_valid, rx_data, 8'(ov_cyc - ov0)} !== {1'b1, 8'h11, 8'd1}) begin
         n_fail++;
         $display("FAIL overrun_second: valid=%b data=%h ov=%0d required 1 11 1",
                  rx_valid, rx_data, ov_cyc - ov0);
      end
      rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_drain: rx_valid=%b required 0", rx_valid);
      end
      n_checks++;
      if (got_n - g0 !== 1 || got_mem[g0[7:0]] !== 8'h11) begin
         n_fail++;
         $display("FAIL overrun_taken: bytes=%0d first=%h required 1 11", got_n - g0, got_mem[g0[7:0]]);
      end
   endtask

   task automatic test_reset_mid;
      int g0, fe0 = fe_cyc, pe0 = pe_cyc, ov0 = ov_cyc;
      logic [7:0] d = 8'hF0;
      baud_div = 16'd8;
      drive_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
      drive_bit(d[4], 4);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: busy=%b required 0", busy);
      end
      @(negedge clk);
      rst = 1'b0;
      g0 = got_n;
      idle(16);
      send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b0, '0);
      idle(16);
      n_checks++;
      if (got_n - g0 !== 1 || got_mem[g0[7:0]] !== 8'h0F) begin
         n_fail++;
         $display("FAIL reset_mid_data: bytes=%0d first=%h required 1 0f", got_n - g0, got_mem[g0[7:0]]);
      end
      n_checks++;
      if (flag_deltas(fe0, pe0, ov0) !== 24'h000000) begin
         n_fail++;
         $display("FAIL reset_mid_flags: fe/pe/ov=%h required 000000", flag_deltas(fe0, pe0, ov0));
      end
   endtask

   // Random bytes and divisors (including values below the minimum) sent with no idle gap;
   // the next frame's divisor is written mid-frame, so it must only take effect at the next start.
   task automatic test_back_to_back;
      localparam int N = 16;
      logic [7:0]       exp_q [$];
      logic [DIV_W-1:0] raw [0:N];
      int g0 = got_n, fe0 = fe_cyc, pe0 = pe_cyc, ov0 = ov_cyc;
      int eff;
      rx_ready = 1'b1;
      for (int i = 0; i <= N; i++) raw[i] = DIV_W'($urandom_range(0, 16));
      baud_div = raw[0];
      for (int i = 0; i < N; i++) begin
         logic [7:0] d = 8'($urandom);
         eff = (raw[i] < 4) ? 4 : int'(raw[i]);
         exp_q.push_back(d);
         send_frame(d, eff, 1'b1, 1'b0, 1'b1, raw[i+1]);
      end
      idle(64);
      n_checks++;
      if (got_n - g0 !== N) begin
         n_fail++;
         $display("FAIL b2b_count: bytes=%0d required %0d", got_n - g0, N);
      end
      for (int i = 0; i < N && i < got_n - g0; i++) begin
         n_checks++;
         if (got_mem[8'(g0 + i)] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL b2b_data[%0d]: rx_data=%h required %h", i, got_mem[8'(g0 + i)], exp_q[i]);
         end
      end
      n_checks++;
      if (flag_deltas(fe0, pe0, ov0) !== 24'h000000) begin
         n_fail++;
         $display("FAIL b2b_flags: fe/pe/ov=%h required 000000", flag_deltas(fe0, pe0, ov0));
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int g0 = got_n, pe0 = pe_cyc;
      baud_div   = 16'd8;
      rx_ready   = 1'b1;
      parity_odd = 1'b0;
      send_frame(8'h07, 8, 1'b1, 1'b1, 1'b0, '0);
      idle(16);
      n_checks++;
      if (got_n - g0 !== 1 || got_mem[g0[7:0]] !== 8'h07 || pe_cyc - pe0 !== 1) begin
         n_fail++;
         $display("FAIL parity_bad: bytes=%0d data=%h pe=%0d required 1 07 1",
                  got_n - g0, got_mem[g0[7:0]], pe_cyc - pe0);
      end
      g0 = got_n; pe0 = pe_cyc;
      send_frame(8'h07, 8, 1'b1, 1'b0, 1'b0, '0);
      parity_odd = 1'b1;
      send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, '0);
      idle(16);
      n_checks++;
      if (got_n - g0 !== 2 || got_mem[g0[7:0]] !== 8'h07 || got_mem[8'(g0 + 1)] !== 8'hA5
          || pe_cyc - pe0 !== 0) begin
         n_fail++;
         $display("FAIL parity_good: bytes=%0d data=%h,%h pe=%0d required 2 07,a5 0",
                  got_n - g0, got_mem[g0[7:0]], got_mem[8'(g0 + 1)], pe_cyc - pe0);
      end
      parity_odd = 1'b0;
   endtask
`endif

   initial begin
      rst      = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      baud_div = 16'd8;
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'b0;
`endif
      @(negedge clk);
      test_reset;
      test_basic;
      test_glitch;
      test_break;
      test_overrun;
      test_reset_mid;
      test_back_to_back;
`ifdef UART_RX_PARITY_EN
      test_parity;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
